// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use stall controller for the 5-stage pipeline.
// Define FWD_UNIT_FORWARDING_EN to enable forwarding; without it every RAW hazard stalls.
module fwd_hazard_unit #(
   parameter int REG_ADDR_W = 4,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_use_src1,
   input  logic                  id_use_src2,
   input  logic                  id_wb_en,
   input  logic [REG_ADDR_W-1:0] id_dest,
   input  logic                  id_mem_read,
   input  logic                  flush,
   output logic                  stall,
   output logic [1:0]            ex_sel_src1,
   output logic [1:0]            ex_sel_src2,
   output logic [CNT_W-1:0]      stall_count
);

`ifdef FWD_UNIT_FORWARDING_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   // The register file writes before it reads, so producers in WB never need tracking.
   logic                  ex_valid, ex_wb_en, ex_mem_read;
   logic [REG_ADDR_W-1:0] ex_dest;
   logic                  mem_valid, mem_wb_en;
   logic [REG_ADDR_W-1:0] mem_dest;
   logic                  m1_ex, m2_ex, m1_mem, m2_mem;
   logic                  hz, load_ex;

   always_comb begin
      m1_ex  = ex_valid  && ex_wb_en  && id_use_src1 && (id_src1 == ex_dest);
      m2_ex  = ex_valid  && ex_wb_en  && id_use_src2 && (id_src2 == ex_dest);
      m1_mem = mem_valid && mem_wb_en && id_use_src1 && (id_src1 == mem_dest);
      m2_mem = mem_valid && mem_wb_en && id_use_src2 && (id_src2 == mem_dest);
   end

   // Without forwarding, a producer still in EX or MEM must drain before the consumer issues.
   assign hz      = id_valid && ((((m1_ex || m2_ex) && (ex_mem_read || !FWD_EN)))
                                 || (!FWD_EN && (m1_mem || m2_mem)));
   assign stall   = hz && !flush;
   assign load_ex = id_valid && !hz && !flush;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid    <= 1'b0;
         ex_wb_en    <= 1'b0;
         ex_mem_read <= 1'b0;
         ex_dest     <= '0;
         mem_valid   <= 1'b0;
         mem_wb_en   <= 1'b0;
         mem_dest    <= '0;
      end else begin
         ex_valid    <= load_ex;
         ex_wb_en    <= id_wb_en;
         ex_mem_read <= id_mem_read;
         ex_dest     <= id_dest;
         mem_valid   <= ex_valid;
         mem_wb_en   <= ex_wb_en;
         mem_dest    <= ex_dest;
      end
   end

`ifdef FWD_UNIT_FORWARDING_EN
   logic [1:0] sel1_next, sel2_next;

   // The youngest producer wins: an EX match will sit in MEM when the consumer reaches EX.
   always_comb begin
      sel1_next = 2'd0;
      sel2_next = 2'd0;
      if (load_ex) begin
         if (m1_ex)
            sel1_next = 2'd1;
         else if (m1_mem)
            sel1_next = 2'd2;
         if (m2_ex)
            sel2_next = 2'd1;
         else if (m2_mem)
            sel2_next = 2'd2;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_sel_src1 <= 2'd0;
         ex_sel_src2 <= 2'd0;
      end else begin
         ex_sel_src1 <= sel1_next;
         ex_sel_src2 <= sel2_next;
      end
   end
`else
   assign ex_sel_src1 = 2'd0;
   assign ex_sel_src2 = 2'd0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if (stall && (stall_count != {CNT_W{1'b1}}))
         stall_count <= stall_count + CNT_W'(1);
   end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage pipelined CPU. It receives each instruction's register usage as it leaves ID and tracks the destination registers of in-flight instructions through EX, MEM and WB. It generates the registered 2-bit select codes that drive the EX-stage operand 3-input muxes: 0 = register file, 1 = MEM-stage result, 2 = WB-stage result. It also raises a combinational stall for load-use hazards and keeps a saturating stall counter.

## Interface
- REG_ADDR_W, default 4: register address width.
- CNT_W, default 16: stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  REG_ADDR_W  source register addresses.
- id_use_src1, id_use_src2  in  1  source is actually read.
- id_wb_en  in  1  instruction writes a register.
- id_dest  in  REG_ADDR_W  destination register.
- id_mem_read  in  1  instruction is a load.
- flush  in  1  taken branch; the instruction leaving ID is killed.
- stall  out  1  combinational; hold IF/ID, insert bubble into EX.
- ex_sel_src1, ex_sel_src2  out  2  registered operand select for the instruction now in EX.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- Tracking entries:
  - EX entry holds {valid, wb_en, mem_read, dest}.
  - MEM entry holds {valid, wb_en, mem_read, dest}.
  - WB entry holds {valid, wb_en, dest}.
- Every cycle the entries shift: EX→MEM→WB. The new EX entry is loaded from the ID inputs, or is a bubble (valid=0) when id_valid=0, stall=1 or flush=1.
- A match for source S against entry E requires all of: E.valid, E.wb_en, use_S, src_S == E.dest.
- Select computed at ID, registered into ex_sel_srcN. The youngest producer wins:
  - match against EX entry → 1, because that producer is in MEM next cycle;
  - else match against MEM entry → 2;
  - else 0.
  - A bubble loads sel 0.
- Load-use hazard (hz): id_valid, and either source matches the EX entry with EX.mem_read=1.
- stall = hz & ~flush.
- The stalled instruction re-evaluates the next cycle. The load is then in MEM, so the instruction receives sel 2.
- stall_count increments by 1 on each cycle with stall=1 and saturates at 2^CNT_W−1.
- The register file is write-before-read, so the WB stage never creates a hazard.

## Timing
- Reset (rst=0, asynchronous): all entries invalid; ex_sel_src1/2=0; stall_count=0. stall=0 because all entries are invalid.
- A reset mid-stream discards all tracked producers immediately.
- Sel latency: ID inputs at cycle N → ex_sel valid for the whole of cycle N+1.
- Stall is combinational from the ID inputs and the EX entry. It is exactly 1 cycle per load-use (with forwarding enabled).
- flush and hz in the same cycle: stall=0, a bubble enters EX, and the counter does not increment.
- flush with no hazard: bubble enters EX and sel=0. Older MEM and WB entries still shift normally.
- id_dest equal to id_src of the same instruction: no self-match, because it is compared against older entries only.
- Both sources matching different stages produce independent selects.
- The counter holds its value at saturation and does not wrap.

## Configuration
- FWD_UNIT_FORWARDING_EN defined: behaviour as above.
- FWD_UNIT_FORWARDING_EN undefined:
  - ex_sel_src1/2 are tied to 0.
  - hz = any ID source matching the EX or MEM entry, load or not.
  - A distance-1 dependency stalls 2 cycles; a distance-2 dependency stalls 1 cycle.
  - flush priority and counter rules are unchanged.

## Test plan
- Reset: drive traffic, then pull rst low mid-cycle → sels=0, stall=0 and stall_count=0 immediately. After release, the first dependent pair shows no stale forwarding.
- Distance 1: ADD R1 then SUB R4,R1,R2 in consecutive cycles → the next cycle has ex_sel_src1=1, ex_sel_src2=0, stall=0.
- Distance 2 and youngest-wins:
  - MOV R3, NOP, ADD R5,R3,R3 → both sels=2.
  - MOV R3, MOV R3, ADD R5,R3 → sel=1.
- Load-use: LDR R2 then ADD R6,R2 → stall=1 for exactly one cycle and stall_count=1. Then the ADD enters EX with ex_sel_src1=2.
- Flush versus stall: LDR R2, then ADD R6,R2 with flush=1 → stall=0, the bubble gives sel=0, and stall_count is unchanged.
- FWD_UNIT_FORWARDING_EN undefined: ADD R1, SUB R4,R1 → stall high 2 cycles, stall_count=2, sels always 0. Counter preloaded to 0xFFFF → stays 0xFFFF after a further stall.
